unified_issue_queue: RTL and testbench

//  Parametrised OoO issue queue between rename/dispatch and functional units (FUs).

---
 rtl/riscv_ooo_pkg.sv | 29 ++
 rtl/iq_select.sv | 22 ++
 rtl/unified_issue_queue.sv | 274 +++++++++++++++++++++++++++
 tb/tb_unified_issue_queue.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ooo_pkg.sv
// Shared out-of-order backend types: FU classes and the default issue-queue entry layout.
package riscv_ooo_pkg;

    localparam int OP_W      = 5;
    localparam int IQ_DATA_W = 32;
    localparam int IQ_PREG_W = 6;
    localparam int IQ_ROB_W  = 4;

    typedef enum logic [0:0] {
        FU_ALU = 1'b0,
        FU_LSU = 1'b1
    } fu_class_e;

    typedef struct packed {
        logic                 valid;
        logic [OP_W-1:0]      op;
        fu_class_e            fu;
        logic [IQ_ROB_W-1:0]  rob;
        logic [IQ_PREG_W-1:0] prd;
        logic [IQ_PREG_W-1:0] prs1;
        logic [IQ_PREG_W-1:0] prs2;
        logic                 rdy1;
        logic                 rdy2;
        logic [IQ_DATA_W-1:0] src1;
        logic [IQ_DATA_W-1:0] src2;
        logic [IQ_DATA_W-1:0] imm;
    } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// Fixed-priority picker: the lowest-index asserted request becomes a one-hot grant.
module iq_select #(
    parameter int N = 16
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         valid
);

    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/unified_issue_queue.sv
// Unified OoO issue queue: dispatch into free slots, operand wakeup from WB broadcasts, per-FU-class select.
// Optional feature macro IQ_WAKEUP_BYPASS_EN: a same-cycle wakeup may issue directly from wb_data.
module unified_issue_queue
    import riscv_ooo_pkg::*;
#(
    parameter int  IQ_DEPTH    = 16,
    parameter int  ISSUE_PORTS = 2,
    parameter int  WB_PORTS    = 2,
    parameter int  DATA_W      = IQ_DATA_W,
    parameter int  PREG_W      = IQ_PREG_W,
    parameter int  ROB_W       = IQ_ROB_W,
    localparam int FU_W        = (ISSUE_PORTS > 1) ? $clog2(ISSUE_PORTS) : 1,
    localparam int CNT_W       = $clog2(IQ_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [OP_W-1:0]               disp_op,
    input  logic [FU_W-1:0]               disp_fu,
    input  logic [ROB_W-1:0]              disp_rob,
    input  logic [PREG_W-1:0]             disp_prd,
    input  logic [PREG_W-1:0]             disp_prs1,
    input  logic                          disp_prs1_rdy,
    input  logic [DATA_W-1:0]             disp_prs1_data,
    input  logic [PREG_W-1:0]             disp_prs2,
    input  logic                          disp_prs2_rdy,
    input  logic [DATA_W-1:0]             disp_prs2_data,
    input  logic [DATA_W-1:0]             disp_imm,
    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]    wb_data,
    output logic [ISSUE_PORTS-1:0]        iss_valid,
    input  logic [ISSUE_PORTS-1:0]        iss_ready,
    output logic [ISSUE_PORTS*OP_W-1:0]   iss_op,
    output logic [ISSUE_PORTS*ROB_W-1:0]  iss_rob,
    output logic [ISSUE_PORTS*PREG_W-1:0] iss_prd,
    output logic [ISSUE_PORTS*DATA_W-1:0] iss_src1,
    output logic [ISSUE_PORTS*DATA_W-1:0] iss_src2,
    output logic [ISSUE_PORTS*DATA_W-1:0] iss_imm,
    output logic [CNT_W-1:0]              iq_count
);

    // Slot layout rebuilt from the module parameters so non-default widths still work.
    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [FU_W-1:0]   fu;
        logic [ROB_W-1:0]  rob;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic              rdy1;
        logic              rdy2;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [DATA_W-1:0] imm;
    } iq_slot_t;

    // Returns {hit, data}; ports are scanned high to low so the lowest matching port wins.
    function automatic logic [DATA_W:0] wb_lookup(
        input logic [PREG_W-1:0]          tag,
        input logic [WB_PORTS-1:0]        v,
        input logic [WB_PORTS*PREG_W-1:0] t,
        input logic [WB_PORTS*DATA_W-1:0] d
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int k = WB_PORTS - 1; k >= 0; k--) begin
            if (v[k] && (t[k*PREG_W +: PREG_W] == tag)) begin
                r = {1'b1, d[k*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    iq_slot_t          iq_q [IQ_DEPTH];
    iq_slot_t          disp_entry;
    logic [DATA_W:0]   wake1 [IQ_DEPTH];
    logic [DATA_W:0]   wake2 [IQ_DEPTH];
    logic [DATA_W-1:0] opnd1 [IQ_DEPTH];
    logic [DATA_W-1:0] opnd2 [IQ_DEPTH];
    logic [DATA_W:0]   disp_wake1;
    logic [DATA_W:0]   disp_wake2;

    logic [IQ_DEPTH-1:0]    eligible;
    logic [IQ_DEPTH-1:0]    slot_free;
    logic [IQ_DEPTH-1:0]    alloc_gnt;
    logic                   alloc_any;
    logic [IQ_DEPTH-1:0]    issue_free;
    logic [IQ_DEPTH-1:0]    port_gnt [ISSUE_PORTS];
    logic [IQ_DEPTH-1:0]    hold_gnt [ISSUE_PORTS];
    logic [ISSUE_PORTS-1:0] hold_any;
    logic [ISSUE_PORTS-1:0] iss_fire;
    logic                   disp_fire;

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            wake1[i] = wb_lookup(iq_q[i].prs1, wb_valid, wb_tag, wb_data);
            wake2[i] = wb_lookup(iq_q[i].prs2, wb_valid, wb_tag, wb_data);
`ifdef IQ_WAKEUP_BYPASS_EN
            eligible[i] = (iq_q[i].rdy1 | wake1[i][DATA_W]) & (iq_q[i].rdy2 | wake2[i][DATA_W]);
            opnd1[i]    = iq_q[i].rdy1 ? iq_q[i].src1 : wake1[i][DATA_W-1:0];
            opnd2[i]    = iq_q[i].rdy2 ? iq_q[i].src2 : wake2[i][DATA_W-1:0];
`else
            eligible[i] = iq_q[i].rdy1 & iq_q[i].rdy2;
            opnd1[i]    = iq_q[i].src1;
            opnd2[i]    = iq_q[i].src2;
`endif
            slot_free[i] = !iq_q[i].valid;
        end
    end

    iq_select #(.N(IQ_DEPTH)) u_alloc (
        .req   (slot_free),
        .gnt   (alloc_gnt),
        .valid (alloc_any)
    );

    assign disp_ready = (iq_count != CNT_W'(IQ_DEPTH));
    assign disp_fire  = disp_valid && disp_ready && alloc_any;

    // Operand capture order: x0, then the dispatch-time ready bit, then a same-cycle broadcast.
    always_comb begin
        disp_wake1       = wb_lookup(disp_prs1, wb_valid, wb_tag, wb_data);
        disp_wake2       = wb_lookup(disp_prs2, wb_valid, wb_tag, wb_data);
        disp_entry       = '0;
        disp_entry.valid = 1'b1;
        disp_entry.op    = disp_op;
        disp_entry.fu    = disp_fu;
        disp_entry.rob   = disp_rob;
        disp_entry.prd   = disp_prd;
        disp_entry.prs1  = disp_prs1;
        disp_entry.prs2  = disp_prs2;
        disp_entry.imm   = disp_imm;
        if (disp_prs1 == '0) begin
            disp_entry.rdy1 = 1'b1;
        end else if (disp_prs1_rdy) begin
            disp_entry.rdy1 = 1'b1;
            disp_entry.src1 = disp_prs1_data;
        end else begin
            disp_entry.rdy1 = disp_wake1[DATA_W];
            disp_entry.src1 = disp_wake1[DATA_W-1:0];
        end
        if (disp_prs2 == '0) begin
            disp_entry.rdy2 = 1'b1;
        end else if (disp_prs2_rdy) begin
            disp_entry.rdy2 = 1'b1;
            disp_entry.src2 = disp_prs2_data;
        end else begin
            disp_entry.rdy2 = disp_wake2[DATA_W];
            disp_entry.src2 = disp_wake2[DATA_W-1:0];
        end
    end

    for (genvar p = 0; p < ISSUE_PORTS; p++) begin : g_port
        logic [IQ_DEPTH-1:0] req;
        logic [IQ_DEPTH-1:0] sel_gnt;
        logic                sel_any;
        logic [OP_W-1:0]     op_mux;
        logic [ROB_W-1:0]    rob_mux;
        logic [PREG_W-1:0]   prd_mux;
        logic [DATA_W-1:0]   src1_mux;
        logic [DATA_W-1:0]   src2_mux;
        logic [DATA_W-1:0]   imm_mux;

        always_comb begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                req[i] = iq_q[i].valid && (iq_q[i].fu == FU_W'(p)) && eligible[i];
            end
        end

        iq_select #(.N(IQ_DEPTH)) u_sel (
            .req   (req),
            .gnt   (sel_gnt),
            .valid (sel_any)
        );

        // A stalled port keeps presenting its entry until the FU accepts it.
        assign hold_any[p]  = |hold_gnt[p];
        assign port_gnt[p]  = hold_any[p] ? hold_gnt[p] : sel_gnt;
        assign iss_valid[p] = !flush && (hold_any[p] || sel_any);

        always_comb begin
            op_mux   = '0;
            rob_mux  = '0;
            prd_mux  = '0;
            src1_mux = '0;
            src2_mux = '0;
            imm_mux  = '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (port_gnt[p][i]) begin
                    op_mux   = iq_q[i].op;
                    rob_mux  = iq_q[i].rob;
                    prd_mux  = iq_q[i].prd;
                    src1_mux = opnd1[i];
                    src2_mux = opnd2[i];
                    imm_mux  = iq_q[i].imm;
                end
            end
        end

        assign iss_op[p*OP_W +: OP_W]       = op_mux;
        assign iss_rob[p*ROB_W +: ROB_W]    = rob_mux;
        assign iss_prd[p*PREG_W +: PREG_W]  = prd_mux;
        assign iss_src1[p*DATA_W +: DATA_W] = src1_mux;
        assign iss_src2[p*DATA_W +: DATA_W] = src2_mux;
        assign iss_imm[p*DATA_W +: DATA_W]  = imm_mux;
    end

    assign iss_fire = iss_valid & iss_ready;

    always_comb begin
        issue_free = '0;
        for (int p = 0; p < ISSUE_PORTS; p++) begin
            if (iss_fire[p]) begin
                issue_free = issue_free | port_gnt[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                iq_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                iq_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (issue_free[i]) begin
                    iq_q[i].valid <= 1'b0;
                end else if (disp_fire && alloc_gnt[i]) begin
                    iq_q[i] <= disp_entry;
                end else if (iq_q[i].valid) begin
                    if (!iq_q[i].rdy1 && wake1[i][DATA_W]) begin
                        iq_q[i].rdy1 <= 1'b1;
                        iq_q[i].src1 <= wake1[i][DATA_W-1:0];
                    end
                    if (!iq_q[i].rdy2 && wake2[i][DATA_W]) begin
                        iq_q[i].rdy2 <= 1'b1;
                        iq_q[i].src2 <= wake2[i][DATA_W-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iq_count <= '0;
        end else if (flush) begin
            iq_count <= '0;
        end else begin
            iq_count <= iq_count + CNT_W'(disp_fire) - CNT_W'($countones(iss_fire));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < ISSUE_PORTS; p++) begin
                hold_gnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < ISSUE_PORTS; p++) begin
                hold_gnt[p] <= (!flush && iss_valid[p] && !iss_ready[p]) ? port_gnt[p] : '0;
            end
        end
    end

endmodule

// File: tb/tb_unified_issue_queue.sv
// Scoreboard bench for unified_issue_queue: a slot-level reference model predicts each cycle's outputs.
`timescale 1ns/1ps
module tb_unified_issue_queue;

    localparam int DEPTH = 16;
    localparam int NP    = 2;
    localparam int NW    = 2;
    localparam int DW    = 32;
    localparam int PW    = 6;
    localparam int RW    = 4;
`ifdef IQ_WAKEUP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [4:0]       disp_op;
    logic [0:0]       disp_fu;
    logic [RW-1:0]    disp_rob;
    logic [PW-1:0]    disp_prd, disp_prs1, disp_prs2;
    logic             disp_prs1_rdy, disp_prs2_rdy;
    logic [DW-1:0]    disp_prs1_data, disp_prs2_data, disp_imm;
    logic [NW-1:0]    wb_valid;
    logic [NW*PW-1:0] wb_tag;
    logic [NW*DW-1:0] wb_data;
    logic [NP-1:0]    iss_valid, iss_ready;
    logic [NP*5-1:0]  iss_op;
    logic [NP*RW-1:0] iss_rob;
    logic [NP*PW-1:0] iss_prd;
    logic [NP*DW-1:0] iss_src1, iss_src2, iss_imm;
    logic [4:0]       iq_count;

    unified_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_fu(disp_fu),
        .disp_rob(disp_rob), .disp_prd(disp_prd),
        .disp_prs1(disp_prs1), .disp_prs1_rdy(disp_prs1_rdy), .disp_prs1_data(disp_prs1_data),
        .disp_prs2(disp_prs2), .disp_prs2_rdy(disp_prs2_rdy), .disp_prs2_data(disp_prs2_data),
        .disp_imm(disp_imm), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_rob(iss_rob),
        .iss_prd(iss_prd), .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_imm(iss_imm),
        .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            v;
        logic [4:0]    op;
        int            fu;
        logic [RW-1:0] rob;
        logic [PW-1:0] prd, prs1, prs2;
        bit            r1, r2;
        logic [DW-1:0] s1, s2, imm;
    } ment_t;

    typedef struct packed {
        logic          v;
        logic [4:0]    op;
        logic [RW-1:0] rob;
        logic [PW-1:0] prd;
        logic [DW-1:0] s1, s2, imm;
    } pexp_t;

    typedef struct packed {
        logic [4:0] count;
        logic       dready;
        pexp_t      p0, p1;
    } exp_t;

    ment_t   m [DEPTH];
    int      hold [NP];
    exp_t    sbq [$];
    int      tests = 0;
    int      fails = 0;
    int      rob_ctr = 0;

    function automatic bit wb_find(input logic [PW-1:0] tag, output logic [DW-1:0] data);
        bit found;
        found = 1'b0;
        data  = '0;
        for (int k = 0; k < NW; k++) begin
            if (!found && wb_valid[k] && wb_tag[k*PW +: PW] == tag) begin
                found = 1'b1;
                data  = wb_data[k*DW +: DW];
            end
        end
        return found;
    endfunction

    function automatic bit operand(input bit r, input logic [PW-1:0] tag, input logic [DW-1:0] s,
                                   output logic [DW-1:0] val);
        logic [DW-1:0] d;
        bit            hit;
        hit = wb_find(tag, d);
        val = r ? s : d;
        return r || (BYPASS && hit);
    endfunction

    task automatic check_output(input string name, input int port, input logic [63:0] got,
                                input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s port %0d: got 0x%0h, expected 0x%0h", name, port, got, want);
        end
    endtask

    task automatic set_idle();
        flush      = 1'b0;
        disp_valid = 1'b0;
        disp_op    = '0;
        disp_fu    = '0;
        disp_rob   = '0;
        disp_prd   = '0;
        disp_prs1  = '0;
        disp_prs2  = '0;
        disp_prs1_rdy  = 1'b0;
        disp_prs2_rdy  = 1'b0;
        disp_prs1_data = '0;
        disp_prs2_data = '0;
        disp_imm   = '0;
        wb_valid   = '0;
        wb_tag     = '0;
        wb_data    = '0;
        iss_ready  = '1;
    endtask

    task automatic load_dispatch(input int fu, input int t1, input bit r1, input logic [DW-1:0] d1,
                                 input int t2, input bit r2, input logic [DW-1:0] d2);
        disp_valid     = 1'b1;
        disp_op        = 5'($urandom);
        disp_fu        = 1'(fu);
        disp_rob       = RW'(rob_ctr);
        disp_prd       = PW'($urandom_range(1, 63));
        disp_prs1      = PW'(t1);
        disp_prs1_rdy  = r1;
        disp_prs1_data = d1;
        disp_prs2      = PW'(t2);
        disp_prs2_rdy  = r2;
        disp_prs2_data = d2;
        disp_imm       = $urandom;
        rob_ctr++;
    endtask

    // Predict this cycle's outputs, queue them, then advance the model across the clock edge.
    task automatic apply_stimulus();
        exp_t          e;
        pexp_t         pe;
        int            sel [NP];
        int            nvalid, free_slot;
        logic [DW-1:0] v1, v2, d;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
            for (int p = 0; p < NP; p++) hold[p] = -1;
        end
        nvalid = 0;
        for (int i = 0; i < DEPTH; i++) if (m[i].v) nvalid++;
        e        = '0;
        e.count  = 5'(nvalid);
        e.dready = (nvalid != DEPTH);
        for (int p = 0; p < NP; p++) begin
            sel[p] = -1;
            pe     = '0;
            if (rst && !flush) begin
                if (hold[p] >= 0) begin
                    sel[p] = hold[p];
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (sel[p] < 0 && m[i].v && m[i].fu == p &&
                            operand(m[i].r1, m[i].prs1, m[i].s1, v1) &&
                            operand(m[i].r2, m[i].prs2, m[i].s2, v2)) sel[p] = i;
                    end
                end
            end
            if (sel[p] >= 0) begin
                void'(operand(m[sel[p]].r1, m[sel[p]].prs1, m[sel[p]].s1, v1));
                void'(operand(m[sel[p]].r2, m[sel[p]].prs2, m[sel[p]].s2, v2));
                pe.v   = 1'b1;
                pe.op  = m[sel[p]].op;
                pe.rob = m[sel[p]].rob;
                pe.prd = m[sel[p]].prd;
                pe.s1  = v1;
                pe.s2  = v2;
                pe.imm = m[sel[p]].imm;
            end
            if (p == 0) e.p0 = pe;
            else        e.p1 = pe;
        end
        sbq.push_back(e);

        if (rst && flush) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
            for (int p = 0; p < NP; p++) hold[p] = -1;
        end else if (rst) begin
            free_slot = -1;
            for (int i = 0; i < DEPTH; i++) if (free_slot < 0 && !m[i].v) free_slot = i;
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].v && !m[i].r1 && wb_find(m[i].prs1, d)) begin m[i].r1 = 1'b1; m[i].s1 = d; end
                if (m[i].v && !m[i].r2 && wb_find(m[i].prs2, d)) begin m[i].r2 = 1'b1; m[i].s2 = d; end
            end
            for (int p = 0; p < NP; p++) begin
                if (sel[p] >= 0 && iss_ready[p]) begin
                    m[sel[p]].v = 1'b0;
                    hold[p]     = -1;
                end else begin
                    hold[p] = sel[p];
                end
            end
            if (disp_valid && nvalid != DEPTH) begin
                m[free_slot].v    = 1'b1;
                m[free_slot].op   = disp_op;
                m[free_slot].fu   = int'(disp_fu);
                m[free_slot].rob  = disp_rob;
                m[free_slot].prd  = disp_prd;
                m[free_slot].prs1 = disp_prs1;
                m[free_slot].prs2 = disp_prs2;
                m[free_slot].imm  = disp_imm;
                m[free_slot].r1 = 1'b1;
                m[free_slot].s1 = '0;
                if (disp_prs1 != 0 && disp_prs1_rdy) m[free_slot].s1 = disp_prs1_data;
                else if (disp_prs1 != 0) begin m[free_slot].r1 = wb_find(disp_prs1, d); m[free_slot].s1 = d; end
                m[free_slot].r2 = 1'b1;
                m[free_slot].s2 = '0;
                if (disp_prs2 != 0 && disp_prs2_rdy) m[free_slot].s2 = disp_prs2_data;
                else if (disp_prs2 != 0) begin m[free_slot].r2 = wb_find(disp_prs2, d); m[free_slot].s2 = d; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t  e;
        pexp_t pe;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check_output("iq_count", -1, 64'(iq_count), 64'(e.count));
                check_output("disp_ready", -1, 64'(disp_ready), 64'(e.dready));
                for (int p = 0; p < NP; p++) begin
                    pe = (p == 0) ? e.p0 : e.p1;
                    check_output("iss_valid", p, 64'(iss_valid[p]), 64'(pe.v));
                    if (pe.v) begin
                        check_output("iss_op", p, 64'(iss_op[p*5 +: 5]), 64'(pe.op));
                        check_output("iss_rob", p, 64'(iss_rob[p*RW +: RW]), 64'(pe.rob));
                        check_output("iss_prd", p, 64'(iss_prd[p*PW +: PW]), 64'(pe.prd));
                        check_output("iss_src1", p, 64'(iss_src1[p*DW +: DW]), 64'(pe.s1));
                        check_output("iss_src2", p, 64'(iss_src2[p*DW +: DW]), 64'(pe.s2));
                        check_output("iss_imm", p, 64'(iss_imm[p*DW +: DW]), 64'(pe.imm));
                    end
                end
            end
        end
    end

    initial begin : driver
        int t0;
        set_idle();
        @(posedge clk);
        #1;
        repeat (2) apply_stimulus();
        rst = 1'b1;
        apply_stimulus();

        // Async reset while five operand-waiting entries are queued
        for (int i = 0; i < 5; i++) begin
            set_idle(); load_dispatch(0, 40 + i, 1'b0, '0, 0, 1'b0, '0); apply_stimulus();
        end
        set_idle(); rst = 1'b0; apply_stimulus();
        rst = 1'b1; apply_stimulus();

        // Both operands ready at dispatch
        set_idle(); load_dispatch(0, 3, 1'b1, 32'd7, 4, 1'b1, 32'd9); apply_stimulus();
        set_idle(); repeat (2) apply_stimulus();

        // Late wakeup on WB port 1
        set_idle(); load_dispatch(0, 12, 1'b0, '0, 0, 1'b1, 32'h55); apply_stimulus();
        set_idle(); apply_stimulus();
        wb_valid = 2'b10; wb_tag = {PW'(12), PW'(0)}; wb_data = {32'hAB, 32'h0}; apply_stimulus();
        set_idle(); repeat (2) apply_stimulus();

        // Fill to capacity, overflow dispatch ignored, one wakeup frees a slot
        for (int i = 0; i < DEPTH; i++) begin
            set_idle(); load_dispatch(i % 2, 20 + i, 1'b0, '0, 20 + i, 1'b0, '0); apply_stimulus();
        end
        set_idle(); load_dispatch(0, 3, 1'b1, 32'd1, 4, 1'b1, 32'd2); apply_stimulus();
        set_idle(); wb_valid = 2'b01; wb_tag = {PW'(0), PW'(25)}; wb_data = {32'h0, 32'h1234}; apply_stimulus();
        set_idle(); repeat (3) apply_stimulus();
        set_idle(); flush = 1'b1; apply_stimulus();

        // Port 1 stalls and holds while port 0 keeps firing
        set_idle(); iss_ready = 2'b01; load_dispatch(1, 5, 1'b1, 32'h11, 6, 1'b1, 32'h22); apply_stimulus();
        set_idle(); iss_ready = 2'b01; load_dispatch(0, 7, 1'b1, 32'h33, 8, 1'b1, 32'h44); apply_stimulus();
        set_idle(); iss_ready = 2'b01; load_dispatch(1, 9, 1'b1, 32'h66, 0, 1'b0, '0); apply_stimulus();
        set_idle(); iss_ready = 2'b01; repeat (2) apply_stimulus();
        set_idle(); repeat (3) apply_stimulus();

        // Flush with eight queued entries and a simultaneous dispatch
        for (int i = 0; i < 8; i++) begin
            set_idle(); load_dispatch(i % 2, 50 + i, 1'b0, '0, 0, 1'b1, '0); apply_stimulus();
        end
        set_idle(); flush = 1'b1; load_dispatch(0, 3, 1'b1, 32'd5, 4, 1'b1, 32'd6); apply_stimulus();
        set_idle(); repeat (3) apply_stimulus();

        // Random traffic with small tag space to force wakeup collisions and port priority
        for (int c = 0; c < 1500; c++) begin
            set_idle();
            if ($urandom_range(0, 9) < 6)
                load_dispatch($urandom_range(0, 1), $urandom_range(0, 7), 1'($urandom), $urandom,
                              $urandom_range(0, 7), 1'($urandom), $urandom);
            wb_valid = 2'($urandom);
            t0       = $urandom_range(0, 7);
            wb_tag   = {($urandom_range(0, 9) < 3) ? PW'(t0) : PW'($urandom_range(0, 7)), PW'(t0)};
            wb_data  = {$urandom, $urandom};
            iss_ready = 2'($urandom);
            flush    = ($urandom_range(0, 49) == 0);
            apply_stimulus();
        end

        set_idle();
        @(negedge clk);
        #1;
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
